// File: rtl/ascon_permutation_unrolled.sv
// rtl/ascon_permutation_unrolled.sv - ASCON pa/pb permutation engine, UNROLL rounds per clock.
// Optional ASCON_PERM_XOR_EN adds x0 data absorb before the first round and {x3,x4} key add after the last.
module ascon_permutation_unrolled #(
    parameter int UNROLL = 1
) (
    input  logic           clock_i,
    input  logic           resetb_i,
    input  logic           start_i,
    input  logic           mode_i,
    input  logic [319:0]   state_i,
`ifdef ASCON_PERM_XOR_EN
    input  logic           xor_begin_i,
    input  logic [63:0]    xor_data_i,
    input  logic           xor_end_i,
    input  logic [127:0]   xor_key_i,
`endif
    output logic [319:0]   state_o,
    output logic [3:0]     round_o,
    output logic           busy_o,
    output logic           done_o
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
        $fatal(1, "ascon_permutation_unrolled: UNROLL must be 1, 2, 3 or 6");
    end

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]   fsm_q, fsm_d;
    logic [319:0] state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;
    logic         start_acc, last, active;
    logic [3:0]   base_round;
    logic [319:0] perm_in, perm_out;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // State word order is {x0, x1, x2, x3, x4}, x0 in the top 64 bits.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'h0, ~r, r};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    assign start_acc  = (fsm_q == S_IDLE) && start_i;
    assign active     = start_acc || (fsm_q == S_RUN);
    assign base_round = start_acc ? (mode_i ? 4'd6 : 4'd0) : round_q;
    assign last       = (({1'b0, base_round} + 5'(UNROLL)) == 5'd12);

`ifdef ASCON_PERM_XOR_EN
    logic xor_end_q, xor_end_d, end_flag;
    assign end_flag = start_acc ? xor_end_i : xor_end_q;
`endif

    always_comb begin
        perm_in = start_acc ? state_i : state_q;
`ifdef ASCON_PERM_XOR_EN
        if (start_acc && xor_begin_i) begin
            perm_in[319:256] = perm_in[319:256] ^ xor_data_i;
        end
`endif
        perm_out = perm_in;
        for (int k = 0; k < UNROLL; k++) begin
            perm_out = ascon_round(perm_out, base_round + 4'(k));
        end
`ifdef ASCON_PERM_XOR_EN
        if (last && end_flag) begin
            perm_out[127:0] = perm_out[127:0] ^ xor_key_i;
        end
`endif
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        done_d  = 1'b0;
        if (active) begin
            state_d = perm_out;
            if (last) begin
                fsm_d   = S_IDLE;
                round_d = 4'd0;
                done_d  = 1'b1;
            end else begin
                fsm_d   = S_RUN;
                round_d = base_round + 4'(UNROLL);
            end
        end
    end

`ifdef ASCON_PERM_XOR_EN
    always_comb begin
        xor_end_d = xor_end_q;
        if (start_acc) begin
            xor_end_d = xor_end_i;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            xor_end_q <= 1'b0;
        end else begin
            xor_end_q <= xor_end_d;
        end
    end
`endif

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= S_IDLE;
            state_q <= 320'h0;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign state_o = state_q;
    assign round_o = round_q;
    assign busy_o  = (fsm_q == S_RUN);
    assign done_o  = done_q;

endmodule

// File: tb/tb_ascon_permutation_unrolled.sv
// tb/tb_ascon_permutation_unrolled.sv - scoreboard bench for ascon_permutation_unrolled.
module tb_ascon_permutation_unrolled;

    localparam int UNROLL = 1;
    localparam logic [319:0] JUNK = {10{32'hdeadbeef}};
    localparam logic [63:0]  IV   = 64'h80400c0600000000;
    localparam logic [127:0] KEY  = {64'h0001020304050607, 64'h08090a0b0c0d0e0f};

    logic         clk = 1'b0;
    logic         resetb = 1'b0;
    logic         start_i = 1'b0;
    logic         mode_i = 1'b0;
    logic [319:0] state_i = '0;
    logic         xor_begin_i = 1'b0;
    logic [63:0]  xor_data_i = '0;
    logic         xor_end_i = 1'b0;
    logic [127:0] xor_key_i = '0;
    logic [319:0] state_o;
    logic [3:0]   round_o;
    logic         busy_o;
    logic         done_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [319:0] state;
        int           cyc;
    } sb_t;
    sb_t sb[$];

    logic [4:0] sbox_t [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    int rot_a [5] = '{19, 61, 1, 10, 7};
    int rot_b [5] = '{28, 39, 6, 17, 41};

    ascon_permutation_unrolled #(.UNROLL(UNROLL)) dut (
        .clock_i     (clk),
        .resetb_i    (resetb),
        .start_i     (start_i),
        .mode_i      (mode_i),
        .state_i     (state_i),
`ifdef ASCON_PERM_XOR_EN
        .xor_begin_i (xor_begin_i),
        .xor_data_i  (xor_data_i),
        .xor_end_i   (xor_end_i),
        .xor_key_i   (xor_key_i),
`endif
        .state_o     (state_o),
        .round_o     (round_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference round: table-driven S-box applied column by column.
    function automatic logic [319:0] model_round(input logic [319:0] s, input int r);
        logic [63:0] x [5];
        logic [63:0] y;
        logic [4:0]  v;
        for (int i = 0; i < 5; i++) x[i] = s[319 - 64 * i -: 64];
        x[2][7:0] = x[2][7:0] ^ {4'(15 - r), 4'(r)};
        for (int b = 0; b < 64; b++) begin
            v = sbox_t[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
            x[0][b] = v[4];
            x[1][b] = v[3];
            x[2][b] = v[2];
            x[3][b] = v[1];
            x[4][b] = v[0];
        end
        for (int i = 0; i < 5; i++) begin
            y = x[i];
            x[i] = y ^ ((y >> rot_a[i]) | (y << (64 - rot_a[i])))
                     ^ ((y >> rot_b[i]) | (y << (64 - rot_b[i])));
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input logic m);
        logic [319:0] t;
        t = s;
        for (int r = (m ? 6 : 0); r < 12; r++) t = model_round(t, r);
        return t;
    endfunction

    task automatic chk_vec(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic m, input logic [319:0] s, input logic [319:0] exp, input int l);
        sb_t e;
        mode_i  = m;
        state_i = s;
        start_i = 1'b1;
        e.state = exp;
        e.cyc   = cyc + l;
        sb.push_back(e);
        tick();
        start_i     = 1'b0;
        state_i     = JUNK;
        mode_i      = ~m;
        xor_begin_i = 1'b0;
        xor_end_i   = 1'b0;
    endtask

    task automatic run_watch(input logic m, input logic [319:0] s, input logic [319:0] exp);
        int l;
        int r0;
        l  = (m ? 6 : 12) / UNROLL;
        r0 = m ? 6 : 0;
        issue(m, s, exp, l);
        for (int i = 1; i <= l; i++) begin
            chk_int("round_o", int'(round_o), (i == l) ? 0 : r0 + UNROLL * i);
            chk_int("busy_o", int'(busy_o), (i < l) ? 1 : 0);
            if (i < l) tick();
        end
        tick();
    endtask

    initial begin : monitor
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=cycle %0d required=no done", cyc);
                end else begin
                    e = sb.pop_front();
                    chk_vec("done_state", state_o, e.state);
                    chk_int("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [319:0] s_init, s_a, s_b, s_c;
        int l_pa;
        l_pa   = 12 / UNROLL;
        s_init = {IV, KEY, KEY};
        s_a    = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0, 64'hffffffffffffffff, 64'h5555aaaa3333cccc};
        s_b    = '0;
        s_c    = {5{64'h0f1e2d3c4b5a6978}};

        #1;
        chk_vec("reset_state", state_o, 320'h0);
        chk_int("reset_round", int'(round_o), 0);
        chk_int("reset_busy", int'(busy_o), 0);
        chk_int("reset_done", int'(done_o), 0);
        tick();
        tick();
        resetb = 1'b1;
        tick();

        run_watch(1'b0, s_init, model_perm(s_init, 1'b0));
        chk_vec("hold_after_done", state_o, model_perm(s_init, 1'b0));
        run_watch(1'b1, s_init, model_perm(s_init, 1'b1));
        run_watch(1'b0, s_a, model_perm(s_a, 1'b0));
        run_watch(1'b1, s_b, model_perm(s_b, 1'b1));

        // start held high: a new run is accepted on every done cycle
        start_i = 1'b1;
        for (int c = 0; c < 3 * l_pa; c++) begin
            sb_t e;
            if (c % l_pa == 0) begin
                mode_i  = 1'b0;
                state_i = (c == 0) ? s_a : ((c == l_pa) ? s_c : s_init);
                e.state = model_perm(state_i, 1'b0);
                e.cyc   = cyc + l_pa;
                sb.push_back(e);
            end else begin
                mode_i  = 1'b1;
                state_i = JUNK ^ 320'(c);
            end
            tick();
        end
        start_i = 1'b0;
        state_i = JUNK;
        tick();

        // start pulse in RUN must be ignored
        issue(1'b0, s_c, model_perm(s_c, 1'b0), l_pa);
        tick();
        start_i = 1'b1;
        mode_i  = 1'b1;
        state_i = s_a;
        tick();
        start_i = 1'b0;
        repeat (l_pa + 2) tick();

        // reset in the middle of a pa run
        issue(1'b0, s_a, model_perm(s_a, 1'b0), l_pa);
        repeat (4) tick();
        #1 resetb = 1'b0;
        #1;
        chk_vec("abort_state", state_o, 320'h0);
        chk_int("abort_busy", int'(busy_o), 0);
        chk_int("abort_round", int'(round_o), 0);
        chk_int("abort_done", int'(done_o), 0);
        sb.delete(sb.size() - 1);
        tick();
        tick();
        resetb = 1'b1;
        tick();
        run_watch(1'b0, s_init, model_perm(s_init, 1'b0));

`ifdef ASCON_PERM_XOR_EN
        xor_key_i   = KEY;
        xor_data_i  = 64'h1;
        xor_begin_i = 1'b1;
        run_watch(1'b0, s_init, model_perm(s_init ^ {64'h1, 256'h0}, 1'b0));
        xor_end_i   = 1'b1;
        run_watch(1'b0, s_init, model_perm(s_init, 1'b0) ^ {192'h0, KEY});
        xor_end_i   = 1'b1;
        run_watch(1'b1, s_a, model_perm(s_a, 1'b1) ^ {192'h0, KEY});
`endif

        repeat (4) tick();
        chk_int("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
